gate_sweep_sequencer: RTL and testbench

Self-test sequencer for the two-input digital-gates datapath: on `start` it steps operand pair (A,B) through 00, 01, 10, 11, waits a programmable settle time per vector, samples the 8-bit gate output bus and compares it against the expected gate values. It sits between the top-level control pins and the gates datapath, owns the datapath's A/B operand inputs while busy, and reports pass/fail plus per-vector diagnostics.

---
 rtl/gate_sweep_pkg.sv | 36 +++
 rtl/gate_sweep_sequencer.sv | 156 +++++++++++++++
 tb/tb_gate_sweep_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep self-test sequencer.
// Defines the FSM state, gate bus bit positions and the golden gate function.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_XOR  = 2;
  localparam int unsigned GATE_NAND = 3;
  localparam int unsigned GATE_NOR  = 4;
  localparam int unsigned GATE_XNOR = 5;
  localparam int unsigned GATE_NOTA = 6;
  localparam int unsigned GATE_NOTB = 7;

  localparam logic [1:0] LAST_VEC = 2'd3;

  function automatic logic [7:0] expected_gates(input logic a, input logic b);
    logic [7:0] g;
    g            = '0;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_XOR]  = a ^ b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XNOR] = ~(a ^ b);
    g[GATE_NOTA] = ~a;
    g[GATE_NOTB] = ~b;
    return g;
  endfunction

endpackage

// File: rtl/gate_sweep_sequencer.sv
// Steps the gates datapath through all four operand pairs, waits a settle time,
// samples the gate bus and reports pass/fail with per-vector diagnostics.
module gate_sweep_sequencer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] gates_in,
  output logic       op_a,
  output logic       op_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] first_diff
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_a_q, op_a_d;
  logic             op_b_q, op_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [7:0]       first_diff_q, first_diff_d;

  logic [7:0]       exp_gates;
  logic [7:0]       diff;
  logic             mismatch;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_mask_d  = fail_mask_q;
    first_diff_d = first_diff_q;

    exp_gates = expected_gates(idx_q[1], idx_q[0]);
    diff      = gates_in ^ exp_gates;
    // An if on equality sends X/Z on the bus down the mismatch branch.
    if (gates_in == exp_gates) mismatch = 1'b0;
    else                       mismatch = 1'b1;

    if (ena) begin
      if (abort && (state_q != ST_IDLE)) begin
        state_d = ST_IDLE;
        op_a_d  = 1'b0;
        op_b_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              state_d      = ST_RUN;
              idx_d        = '0;
              cnt_d        = '0;
              op_a_d       = 1'b0;
              op_b_d       = 1'b0;
              busy_d       = 1'b1;
              pass_d       = 1'b0;
              fail_mask_d  = '0;
              first_diff_d = '0;
            end
          end
          ST_RUN: begin
            if (cnt_q == CNT_LAST) begin
              if (mismatch) begin
                fail_mask_d[idx_q] = 1'b1;
                if (first_diff_q == 8'h00) first_diff_d = diff;
              end
              cnt_d = '0;
              if (idx_q != LAST_VEC) begin
                idx_d            = idx_q + 2'd1;
                {op_a_d, op_b_d} = idx_q + 2'd1;
              end else begin
                state_d = ST_DONE;
                op_a_d  = 1'b0;
                op_b_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_mask_d == 4'b0000);
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
          default: begin
            state_d = ST_IDLE;
            op_a_d  = 1'b0;
            op_b_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      op_a_q       <= 1'b0;
      op_b_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= '0;
      first_diff_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_mask_q  <= fail_mask_d;
      first_diff_q <= first_diff_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = fail_mask_q;
  assign first_diff = first_diff_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: a fault-injectable gates datapath model drives
// gates_in; results and cycle timing are checked against tables and a sweep model.
module tb_gate_sweep_sequencer;

  localparam int S_MAIN = 2;
  localparam int STEP   = S_MAIN + 1;
  localparam int SWEEP  = 4 * STEP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, start, abort;
  logic [7:0] gates_in;
  logic       op_a, op_b, busy, done, pass;
  logic [3:0] fail_mask;
  logic [7:0] first_diff;

  logic       start0;
  logic [7:0] gates0;
  logic       op_a0, op_b0, busy0, done0, pass0;
  logic [3:0] fail_mask0;
  logic [7:0] first_diff0;

  logic [7:0] stuck1;
  logic [7:0] flip [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] good_gates(input logic a, input logic b);
    return {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  assign gates_in = (good_gates(op_a, op_b) | stuck1) ^ flip[{op_a, op_b}];
  assign gates0   = good_gates(op_a0, op_b0);

  gate_sweep_sequencer #(.SETTLE_CYCLES(S_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .gates_in(gates_in), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .first_diff(first_diff)
  );

  gate_sweep_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .start(start0), .abort(1'b0),
    .gates_in(gates0), .op_a(op_a0), .op_b(op_b0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_mask(fail_mask0), .first_diff(first_diff0)
  );

  typedef struct {
    logic [7:0]  stuck1;
    logic [31:0] flips;     // {v3, v2, v1, v0}
    logic [3:0]  fm;
    logic [7:0]  fd;
    logic        pass;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected {busy, done, op_a, op_b} after p enabled edges past start acceptance.
  function automatic logic [3:0] exp_status(input int p);
    if (p < SWEEP)       return {2'b10, 2'(p / STEP)};
    else if (p == SWEEP) return 4'b0100;
    else                 return 4'b0000;
  endfunction

  // Result of sampling the first nvec vectors of the faulty datapath.
  task automatic ref_result(input int nvec, output logic [3:0] fm, output logic [7:0] fd);
    logic [7:0] g, d;
    fm = '0;
    fd = '0;
    for (int v = 0; v < nvec; v++) begin
      g = good_gates(v[1], v[0]);
      d = ((g | stuck1) ^ flip[v]) ^ g;
      if (d != 0) begin
        if (fm == 0) fd = d;
        fm[v] = 1'b1;
      end
    end
  endtask

  task automatic set_fault(input logic [7:0] s1, input logic [31:0] fl);
    stuck1 = s1;
    for (int v = 0; v < 4; v++) flip[v] = fl[8*v +: 8];
  endtask

  task automatic sweep(input string tag, input int hold_at, input int hold_len,
                       input logic [3:0] efm, input logic [7:0] efd, input logic epass);
    int p;
    int k;
    @(negedge clk);
    ena = 1'b1; abort = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p = 0;
    check({tag, ":accept"}, 32'({busy, done, op_a, op_b}), 32'(exp_status(p)));
    k = 0;
    while (p < SWEEP && k < 80) begin
      ena   = !(k >= hold_at && k < hold_at + hold_len);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ena) p++;
      k++;
      check({tag, ":step"}, 32'({busy, done, op_a, op_b}), 32'(exp_status(p)));
    end
    if (p != SWEEP) check({tag, ":timeout"}, 32'(p), 32'(SWEEP));
    check({tag, ":fail_mask"}, 32'(fail_mask), 32'(efm));
    check({tag, ":first_diff"}, 32'(first_diff), 32'(efd));
    check({tag, ":pass"}, 32'(pass), 32'(epass));
    ena = 1'b0; start = 1'b1;
    @(negedge clk);
    check({tag, ":done_frozen"}, 32'({busy, done, op_a, op_b}), 32'(4'b0100));
    ena = 1'b1;
    @(negedge clk);
    check({tag, ":done_end"}, 32'({busy, done, op_a, op_b}), 32'(4'b0000));
    start = 1'b0;
    @(negedge clk);
    check({tag, ":idle"}, 32'({busy, done, pass, fail_mask, first_diff}),
          32'({2'b00, epass, efm, efd}));
  endtask

  vec_t tbl [5];

  initial begin
    logic [3:0] mfm;
    logic [7:0] mfd;
    logic [31:0] rfl;
    int hold;

    tbl[0] = '{stuck1: 8'h00, flips: 32'h0000_0000, fm: 4'b0000, fd: 8'h00, pass: 1'b1};
    tbl[1] = '{stuck1: 8'h01, flips: 32'h0000_0000, fm: 4'b0111, fd: 8'h01, pass: 1'b0};
    tbl[2] = '{stuck1: 8'h00, flips: 32'h8000_0000, fm: 4'b1000, fd: 8'h80, pass: 1'b0};
    tbl[3] = '{stuck1: 8'h00, flips: 32'h0001_2400, fm: 4'b0110, fd: 8'h24, pass: 1'b0};
    tbl[4] = '{stuck1: 8'h80, flips: 32'h0000_0000, fm: 4'b1010, fd: 8'h80, pass: 1'b0};

    rst_n = 1'b0; ena = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0;
    set_fault(8'h00, 32'h0);
    #12;
    check("reset_status", 32'({busy, done, op_a, op_b, pass}), 32'(0));
    check("reset_diag", 32'({fail_mask, first_diff}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_fault(tbl[i].stuck1, tbl[i].flips);
      sweep($sformatf("tbl%0d", i), -1, 0, tbl[i].fm, tbl[i].fd, tbl[i].pass);
    end

    set_fault(8'h00, 32'h0);
    sweep("ena_hold", 5, 4, 4'b0000, 8'h00, 1'b1);

    // Abort on the fifth RUN cycle with bit0 stuck: only vector 00 has been sampled.
    set_fault(8'h01, 32'h0);
    @(negedge clk);
    ena = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre", 32'({busy, done, op_a, op_b}), 32'(exp_status(4)));
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    ref_result(4 / STEP, mfm, mfd);
    check("abort_status", 32'({busy, done, op_a, op_b, pass}), 32'(0));
    check("abort_partial", 32'({fail_mask, first_diff}), 32'({mfm, mfd}));
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (SWEEP) begin
        @(negedge clk);
        saw_done = saw_done | done | busy;
      end
      check("abort_no_done", 32'(saw_done), 32'(0));
    end

    // Asynchronous reset in the middle of a sweep, away from any edge.
    set_fault(8'h00, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 32'({busy, done, op_a, op_b, pass, fail_mask, first_diff}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_rst", -1, 0, 4'b0000, 8'h00, 1'b1);

    // Randomized faults and enable holds against the reference model.
    for (int r = 0; r < 6; r++) begin
      rfl = $urandom;
      for (int v = 0; v < 4; v++) if ($urandom_range(0, 1) == 0) rfl[8*v +: 8] = 8'h00;
      set_fault(($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, rfl);
      ref_result(4, mfm, mfd);
      hold = $urandom_range(0, 10);
      sweep($sformatf("rnd%0d", r), hold, $urandom_range(0, 3), mfm, mfd, mfm == 0);
    end

    // S=0 instance with start held: back-to-back sweeps, period 6.
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      int ph;
      logic [3:0] e;
      @(negedge clk);
      ph = c % 6;
      if (ph < 4)       e = {2'b10, 2'(ph)};
      else if (ph == 4) e = 4'b0100;
      else              e = 4'b0000;
      check($sformatf("s0_cyc%0d", c), 32'({busy0, done0, op_a0, op_b0}), 32'(e));
      if (ph == 4) check("s0_pass", 32'({pass0, fail_mask0, first_diff0}), 32'({1'b1, 12'h000}));
    end
    start0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
